// File: rtl/bcd_display_sequencer_pkg.sv
// rtl/bcd_display_sequencer_pkg.sv - shared types and segment constants for the BCD display sequencer
// Contents: controller state enum, active-low segment codes {dp,g,f,e,d,c,b,a},
// digit count, and the shift-add-3 nibble correction helper.
package bcd_disp_pkg;

  localparam int DIGITS = 6;

  typedef enum logic [1:0] {IDLE, CONVERT, SCAN, DONE} state_t;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_ERR   = 8'h7F;

  localparam logic [7:0] SEG_DIGIT [0:9] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
    8'h92, 8'h82, 8'hF8, 8'h80, 8'h90
  };

  // Double-dabble correction: a nibble of 5 or more would exceed 9 after the
  // next shift, so pre-add 3 to carry it into the next decimal place.
  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

endpackage

// File: rtl/bcd_display_sequencer_if.sv
// rtl/bcd_display_sequencer_if.sv - load handshake bundle between producer and display sequencer
// Signals: value_in (binary value), load (request), ready (idle), done (update pulse),
// overflow (last accepted value out of range).
// master: drives value_in/load; slave: drives ready/done/overflow.
interface bcd_display_sequencer_if #(
  parameter int WIDTH = 20
) ();
  logic [WIDTH-1:0] value_in;
  logic             load;
  logic             ready;
  logic             done;
  logic             overflow;

  modport master (output value_in, output load, input ready, input done, input overflow);
  modport slave  (input value_in, input load, output ready, output done, output overflow);
endinterface

// File: rtl/bcd_display_sequencer_seg_decode.sv
// rtl/bcd_display_sequencer_seg_decode.sv - combinational BCD nibble to active-low 7-segment decoder
// Ports: nibble (4-bit BCD digit in), seg (8-bit active-low {dp,g,f,e,d,c,b,a} out).
// Non-decimal nibbles 10-15 show the error pattern.
module bcd_seg_decode
  import bcd_disp_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [7:0] seg
);

  always_comb begin
    seg = SEG_ERR;
    case (nibble)
      4'd0: seg = SEG_DIGIT[0];
      4'd1: seg = SEG_DIGIT[1];
      4'd2: seg = SEG_DIGIT[2];
      4'd3: seg = SEG_DIGIT[3];
      4'd4: seg = SEG_DIGIT[4];
      4'd5: seg = SEG_DIGIT[5];
      4'd6: seg = SEG_DIGIT[6];
      4'd7: seg = SEG_DIGIT[7];
      4'd8: seg = SEG_DIGIT[8];
      4'd9: seg = SEG_DIGIT[9];
      default: seg = SEG_ERR;
    endcase
  end

endmodule

// File: rtl/bcd_display_sequencer.sv
// rtl/bcd_display_sequencer.sv - binary to six-digit 7-segment display sequencer
// Ports: clk, rst (synchronous, active-high); bus (slave: value_in, load, ready,
// done, overflow); HEX0..HEX5 registered active-low segment outputs, HEX0 = LSD.
// Flow: IDLE -> CONVERT (WIDTH shift-add-3 steps) -> SCAN (one digit per clock
// through a single shared decoder) -> DONE -> IDLE.
module bcd_display_sequencer #(
  parameter int          WIDTH    = 20,
  parameter int          DIGITS   = 6,
  parameter bit          LZ_BLANK = 1'b1,
  parameter int unsigned MAX_VAL  = 999999
) (
  input  logic                     clk,
  input  logic                     rst,
  bcd_display_sequencer_if.slave   bus,
  output logic [7:0]               HEX0,
  output logic [7:0]               HEX1,
  output logic [7:0]               HEX2,
  output logic [7:0]               HEX3,
  output logic [7:0]               HEX4,
  output logic [7:0]               HEX5
);
  import bcd_disp_pkg::*;

  localparam int CW = $clog2(WIDTH);

  state_t                state;
  logic [WIDTH-1:0]      bin;
  logic [4*DIGITS-1:0]   bcd;
  logic [4*DIGITS-1:0]   bcd_adj;
  logic [CW-1:0]         cnt;
  logic [2:0]            idx;
  logic [7:0]            hex_q [DIGITS];
  logic                  ready_q;
  logic                  done_q;
  logic                  ovf_q;
  logic [3:0]            nib;
  logic [7:0]            dec_seg;
  logic [7:0]            digit_code;
  logic                  upper_zero;

  always_comb begin
    bcd_adj = '0;
    for (int i = 0; i < DIGITS; i++) begin
      bcd_adj[4*i +: 4] = add3(bcd[4*i +: 4]);
    end
  end

  assign nib = bcd[4*idx +: 4];

  bcd_seg_decode u_dec (
    .nibble (nib),
    .seg    (dec_seg)
  );

  // Leading-zero test: this digit and everything above it are zero.
  always_comb begin
    upper_zero = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (i >= int'(idx) && bcd[4*i +: 4] != 4'd0) upper_zero = 1'b0;
    end
  end

  always_comb begin
    digit_code = dec_seg;
    if (ovf_q)                                     digit_code = SEG_ERR;
    else if (LZ_BLANK && idx != 3'd0 && upper_zero) digit_code = SEG_BLANK;
  end

  // ready/done trail the state by one clock, so a load is taken only when
  // both the state is IDLE and ready has already been presented as high.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      bin     <= '0;
      bcd     <= '0;
      cnt     <= '0;
      idx     <= '0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      for (int i = 0; i < DIGITS; i++) hex_q[i] <= SEG_BLANK;
    end else begin
      ready_q <= (state == IDLE);
      done_q  <= (state == DONE);
      case (state)
        IDLE: begin
          if (bus.load && ready_q) begin
            bin   <= bus.value_in;
            ovf_q <= 32'(bus.value_in) > MAX_VAL;
            bcd   <= '0;
            cnt   <= '0;
            state <= CONVERT;
          end
        end
        CONVERT: begin
          // Bits leaving the top of bcd are dropped; overflow flags that case.
          bcd <= {bcd_adj[4*DIGITS-2:0], bin[WIDTH-1]};
          bin <= bin << 1;
          if (cnt == CW'(WIDTH - 1)) begin
            idx   <= '0;
            state <= SCAN;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        SCAN: begin
          hex_q[idx] <= digit_code;
          if (idx == 3'(DIGITS - 1)) state <= DONE;
          else                       idx   <= idx + 3'd1;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ready    = ready_q;
  assign bus.done     = done_q;
  assign bus.overflow = ovf_q;

  assign HEX0 = hex_q[0];
  assign HEX1 = hex_q[1];
  assign HEX2 = hex_q[2];
  assign HEX3 = hex_q[3];
  assign HEX4 = hex_q[4];
  assign HEX5 = hex_q[5];

endmodule

// File: tb/tb_bcd_display_sequencer.sv
// tb/tb_bcd_display_sequencer.sv - self-checking bench for bcd_display_sequencer (blanking on and off)
module tb_bcd_display_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [19:0] value = '0;

  always #5 clk = ~clk;

  bcd_display_sequencer_if #(.WIDTH(20)) bus1 ();
  bcd_display_sequencer_if #(.WIDTH(20)) bus0 ();

  assign bus1.load = load;
  assign bus1.value_in = value;
  assign bus0.load = load;
  assign bus0.value_in = value;

  logic [7:0] a0, a1, a2, a3, a4, a5;
  logic [7:0] b0, b1, b2, b3, b4, b5;

  bcd_display_sequencer #(.WIDTH(20), .DIGITS(6), .LZ_BLANK(1'b1), .MAX_VAL(999999)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1),
    .HEX0(a0), .HEX1(a1), .HEX2(a2), .HEX3(a3), .HEX4(a4), .HEX5(a5)
  );

  bcd_display_sequencer #(.WIDTH(20), .DIGITS(6), .LZ_BLANK(1'b0), .MAX_VAL(999999)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0),
    .HEX0(b0), .HEX1(b1), .HEX2(b2), .HEX3(b3), .HEX4(b4), .HEX5(b5)
  );

  int vectors = 0;
  int errors  = 0;
  int done_cnt = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference: decimal digit i of v from plain arithmetic.
  logic [7:0] seg_tab [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  function automatic logic [7:0] mcode(input int v, input int i, input bit lz);
    int p;
    p = 1;
    for (int j = 0; j < i; j++) p = p * 10;
    if (v > 999999) return 8'h7F;
    if (lz && i > 0 && v < p) return 8'hFF;
    return seg_tab[(v / p) % 10];
  endfunction

  // Timeline model: a load accepted at edge k writes digit i at edge k+21+i,
  // pulses done after edge k+27, holds ready low after edges k+1..k+27, and the
  // next load can be accepted at edge k+29 at the earliest.
  bit         mvalid = 1'b0;
  int         ecnt, kacc, mval;
  logic [7:0] exp1 [6];
  logic [7:0] exp0 [6];
  bit         exp_ready, exp_done, exp_ovf;

  always @(posedge clk) begin
    if (rst) begin
      mvalid = 1'b1;
      ecnt = 0;
      kacc = -1;
      mval = 0;
      exp_ready = 1'b1;
      exp_done = 1'b0;
      exp_ovf = 1'b0;
      for (int i = 0; i < 6; i++) begin
        exp1[i] = 8'hFF;
        exp0[i] = 8'hFF;
      end
    end else if (mvalid) begin
      bit acc;
      ecnt++;
      acc = load && (kacc < 0 || ecnt >= kacc + 29);
      if (kacc >= 0) begin
        for (int i = 0; i < 6; i++) begin
          if (ecnt == kacc + 21 + i) begin
            exp1[i] = mcode(mval, i, 1'b1);
            exp0[i] = mcode(mval, i, 1'b0);
          end
        end
      end
      if (acc) begin
        kacc = ecnt;
        mval = int'(value);
        exp_ovf = (int'(value) > 999999);
      end
      exp_ready = !(kacc >= 0 && ecnt >= kacc + 1 && ecnt <= kacc + 27);
      exp_done  = (kacc >= 0 && ecnt == kacc + 27);
    end
  end

  always @(negedge clk) begin
    if (mvalid) begin
      logic [7:0] g1 [6];
      logic [7:0] g0 [6];
      g1 = '{a0, a1, a2, a3, a4, a5};
      g0 = '{b0, b1, b2, b3, b4, b5};
      if (bus1.done === 1'b1) done_cnt++;
      chk("ready1", 32'(bus1.ready), 32'(exp_ready));
      chk("done1", 32'(bus1.done), 32'(exp_done));
      chk("ovf1", 32'(bus1.overflow), 32'(exp_ovf));
      chk("ready0", 32'(bus0.ready), 32'(exp_ready));
      chk("done0", 32'(bus0.done), 32'(exp_done));
      chk("ovf0", 32'(bus0.overflow), 32'(exp_ovf));
      for (int i = 0; i < 6; i++) begin
        chk($sformatf("hex_lz1[%0d]", i), 32'(g1[i]), 32'(exp1[i]));
        chk($sformatf("hex_lz0[%0d]", i), 32'(g0[i]), 32'(exp0[i]));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (bus1.ready !== 1'b1 && n < 100) begin
      tick(1);
      n++;
    end
    chk("ready_wait", 32'(bus1.ready), 32'd1);
  endtask

  // Single-cycle load pulse, then wait past the whole transaction.
  task automatic load_val(input int v);
    wait_ready();
    load = 1'b1;
    value = 20'(v);
    tick(1);
    load = 1'b0;
    tick(30);
  endtask

  // Literal check, expected given as {HEX5,...,HEX0}.
  task automatic lit1(input string name, input logic [47:0] e);
    logic [47:0] g;
    g = {a5, a4, a3, a2, a1, a0};
    for (int i = 0; i < 6; i++) chk($sformatf("%s_lz1_hex%0d", name, i), 32'(g[8*i +: 8]), 32'(e[8*i +: 8]));
  endtask

  task automatic lit0(input string name, input logic [47:0] e);
    logic [47:0] g;
    g = {b5, b4, b3, b2, b1, b0};
    for (int i = 0; i < 6; i++) chk($sformatf("%s_lz0_hex%0d", name, i), 32'(g[8*i +: 8]), 32'(e[8*i +: 8]));
  endtask

  initial begin
    int d0;
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(2);
    lit1("reset", 48'hFFFF_FFFF_FFFF);
    chk("reset_ready", 32'(bus1.ready), 32'd1);
    chk("reset_done", 32'(bus1.done), 32'd0);
    chk("reset_ovf", 32'(bus1.overflow), 32'd0);

    d0 = done_cnt;
    load_val(123456);
    lit1("v123456", 48'hF9A4_B099_9282);
    chk("v123456_done_pulses", 32'(done_cnt - d0), 32'd1);

    load_val(907);
    lit1("v907", 48'hFFFF_FF90_C0F8);
    lit0("v907", 48'hC0C0_C090_C0F8);
    load_val(0);
    lit1("v0", 48'hFFFF_FFFF_FFC0);
    load_val(999999);
    lit1("v999999", 48'h9090_9090_9090);
    chk("v999999_ovf", 32'(bus1.overflow), 32'd0);
    load_val(1000000);
    lit1("v1000000", 48'h7F7F_7F7F_7F7F);
    chk("v1000000_ovf", 32'(bus1.overflow), 32'd1);
    load_val(1048575);
    lit1("v1048575", 48'h7F7F_7F7F_7F7F);

    // Load pulse while busy is dropped.
    wait_ready();
    d0 = done_cnt;
    load = 1'b1; value = 20'd111111;
    tick(1);
    load = 1'b0;
    tick(4);
    load = 1'b1; value = 20'd222222;
    tick(1);
    load = 1'b0;
    tick(40);
    lit1("busy", 48'hF9F9_F9F9_F9F9);
    chk("busy_done_pulses", 32'(done_cnt - d0), 32'd1);

    // Held load is re-accepted once idle.
    load = 1'b1; value = 20'd333333;
    tick(70);
    load = 1'b0;
    tick(35);
    lit1("held", 48'hB0B0_B0B0_B0B0);

    // Reset during CONVERT and during SCAN.
    wait_ready();
    load = 1'b1; value = 20'd555555;
    tick(1);
    load = 1'b0;
    tick(9);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    lit1("rst_conv", 48'hFFFF_FFFF_FFFF);
    chk("rst_conv_ready", 32'(bus1.ready), 32'd1);
    d0 = done_cnt;
    load = 1'b1; value = 20'd654321;
    tick(1);
    load = 1'b0;
    tick(22);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    lit1("rst_scan", 48'hFFFF_FFFF_FFFF);
    tick(10);
    chk("rst_scan_no_done", 32'(done_cnt - d0), 32'd0);
    // rst and load on the same edge: load dropped.
    rst = 1'b1; load = 1'b1; value = 20'd777;
    tick(1);
    rst = 1'b0; load = 1'b0;
    tick(5);
    chk("rst_load_ready", 32'(bus1.ready), 32'd1);
    lit1("rst_load", 48'hFFFF_FFFF_FFFF);
    load_val(42);
    lit1("v42", 48'hFFFF_FFFF_99A4);
    lit0("v42", 48'hC0C0_C0C0_99A4);

    // Randomized traffic against the timeline model.
    for (int c = 0; c < 2500; c++) begin
      int r;
      rst  = ($urandom_range(0, 299) == 0);
      load = ($urandom_range(0, 3) == 0);
      r = int'($urandom_range(0, 3));
      case (r)
        0: value = 20'($urandom_range(0, 9));
        1: value = 20'($urandom_range(0, 99999));
        2: value = 20'($urandom_range(0, 999999));
        default: value = 20'($urandom_range(0, 20'hFFFFF));
      endcase
      tick(1);
    end
    rst = 1'b0;
    load = 1'b0;
    tick(40);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/bcd_display_sequencer.md
Name: bcd_display_sequencer

Overview:
Sequential controller that takes a binary value and drives all six DE10-Lite 7-segment digits (HEX5..HEX0) with its decimal form. It converts binary to BCD with an iterative shift-add-3 engine. It then time-shares a single BCD-to-7-segment decoder across the six digits, one digit per clock, into registered outputs. It sits between the counter/measurement logic and the board HEX pins, with a valid/ready load handshake.

Parameters:
WIDTH, 20, binary input width; conversion takes WIDTH cycles.
DIGITS, 6, number of BCD digits / HEX outputs; only the default is supported.
LZ_BLANK, 1, 1 = blank leading zeros; 0 = show all digits.
MAX_VAL, 999999, largest displayable value; above this, show the error pattern.

Ports:
clk  input  1  system clock (MAX10_CLK1_50 domain)
rst  input  1  synchronous reset, active-high
value_in  input  WIDTH  binary value to display
load  input  1  request; accepted only when ready=1
ready  output  1  high only in IDLE
done  output  1  one-cycle pulse when all HEX outputs are updated
overflow  output  1  registered; 1 when last accepted value > MAX_VAL
HEX0..HEX5  output  8 each  active-low segments {dp,g,f,e,d,c,b,a}; HEX0 is the least-significant digit

Behaviour:
- One clock; reset is synchronous and active-high (rst sampled on rising clk).
- Reset values: HEX0..HEX5 = 8'hFF (all off), ready=1, done=0, overflow=0, state IDLE, BCD shift register = 0.
- Segment codes, active-low:
  - Digits 0-9: C0, F9, A4, B0, 99, 92, 82, F8, 80, 90.
  - Blank: FF.
  - Error: 7F (decimal point only).
- State IDLE:
  - ready=1.
  - On load=1 at edge k: capture value_in; set overflow = (value_in > MAX_VAL); clear the BCD register; go to CONVERT with iteration counter = 0.
- State CONVERT (edges k+1..k+WIDTH):
  - Each edge, add 3 to every BCD nibble >= 5.
  - Then shift {bcd, bin} left by one.
  - Exit after WIDTH iterations to SCAN with digit index 0.
  - BCD register is 4*DIGITS bits; bits shifted out of the top are discarded (the overflow flag covers this case).
- State SCAN (edges k+WIDTH+1..k+WIDTH+6):
  - Each edge, write HEX[idx] from the shared decoder output, then idx++.
  - The decoder input is the nibble selected by idx.
  - Digit value rule per digit:
    - If overflow=1: 7F.
    - Else if LZ_BLANK=1, idx>0, and all nibbles idx..5 are 0: FF.
    - Else: the digit code.
  - HEX0 is never blanked, so value 0 shows "0".
  - After idx=5, go to DONE.
- State DONE: done=1 for exactly that cycle; next edge returns to IDLE.
- Timing: load at edge k gives done high in the cycle after edge k+27 (default WIDTH). ready is low from edge k+1 until edge k+28.
- HEX outputs are not cleared at load. Each digit retains its old value until its own SCAN write, so intermediate mixed values are permitted.
- load while ready=0 is ignored, not queued; a held load is re-accepted on the first IDLE cycle.
- rst in any state aborts immediately: next edge gives the full reset values (HEX blanked).
- rst and load at the same edge: rst wins and load is dropped.
- Conversion nibbles are never > 9 in SCAN when overflow=0. The decoder maps nibbles 10-15 to 7F (defensive).

Decomposition:
- Package bcd_disp_pkg holds:
  - state enum {IDLE, CONVERT, SCAN, DONE};
  - SEG_DIGIT[0:9] active-low constants;
  - SEG_BLANK=8'hFF and SEG_ERR=8'h7F;
  - DIGITS=6.
- Sub-module bcd_seg_decode: combinational, 4-bit nibble in, 8-bit active-low code out, default SEG_ERR. It is instantiated once and shared across the digits by the SCAN index.

Test Plan:
- rst=1 for 2 cycles, then idle → HEX0..5=FF, ready=1, done=0, overflow=0.
- load value 123456 → after edge k+26: HEX5..HEX0 = F9,A4,B0,99,92,82; done=1 for exactly one cycle after edge k+27; ready=1 again after edge k+28.
- LZ_BLANK=1: load 907 → HEX2=90, HEX1=C0, HEX0=F8, HEX5..3=FF. Then load 0 → HEX0=C0, others FF. With LZ_BLANK=0, load 907 → HEX5..3=C0.
- Boundaries: load 999999 → all six = 90, overflow=0. load 1000000 → all six = 7F, overflow=1. load 1048575 → all 7F.
- Busy handling: load 111111, pulse load with 222222 at k+5 → display shows 111111 and only one done pulse. Holding load high with 333333 → re-accepted at the first IDLE edge.
- Reset mid-operation: assert rst at k+10 (CONVERT) and again during SCAN at k+23 → next edge HEX all FF, ready=1, no done pulse. A following load of 42 completes normally: HEX1=99, HEX0=A4.
